// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory handshake plus the decode-side interface.
// The master side is the fetch unit; the slave side is memory/decode.
interface instr_fetch_unit_if;
  logic [31:0] Alt_PC_IN;
  logic        Request_Alt_PC_IN;
  logic        WANT_FREEZE_IN;
  logic        IMem_Req_OUT;
  logic [31:0] IMem_Addr_OUT;
  logic        IMem_Ack_IN;
  logic [31:0] IMem_Data_IN;
  logic [31:0] Instr1_OUT;
  logic [31:0] Instr_PC_OUT;
  logic [31:0] Instr_PC_Plus4_OUT;
  logic        Instr_Valid_OUT;

  modport master (
    input  Alt_PC_IN, Request_Alt_PC_IN, WANT_FREEZE_IN, IMem_Ack_IN, IMem_Data_IN,
    output IMem_Req_OUT, IMem_Addr_OUT, Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4_OUT,
           Instr_Valid_OUT
  );

  modport slave (
    output Alt_PC_IN, Request_Alt_PC_IN, WANT_FREEZE_IN, IMem_Ack_IN, IMem_Data_IN,
    input  IMem_Req_OUT, IMem_Addr_OUT, Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4_OUT,
           Instr_Valid_OUT
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC generation, single-outstanding IMem requests with credit against a small
// fetch queue, redirect/squash handling, and one instruction (or bubble) per cycle to decode.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0040_0000,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0000,
  parameter int unsigned QUEUE_DEPTH = 2
) (
  input logic                CLK,
  input logic                RESET,
  instr_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {StIdle, StReq, StSquash} state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  localparam logic [2:0] Depth = 3'(QUEUE_DEPTH);

  state_e      state_q;
  logic [31:0] pc_q, addr_q;
  entry_t      q_q [QUEUE_DEPTH];
  entry_t      q_d [QUEUE_DEPTH];
  logic [2:0]  count_q, count_d, tail;

  logic [31:0] instr_q, ipc_q, ipc4_q;
  logic        valid_q;

  logic        redirect, freeze, ack, do_pop, do_push, space_ok;
  logic [31:0] alt_pc;
  logic        unused_alt_lsb;

  assign redirect       = bus.Request_Alt_PC_IN;
  assign freeze         = bus.WANT_FREEZE_IN;
  assign ack            = bus.IMem_Ack_IN;
  assign alt_pc         = {bus.Alt_PC_IN[31:2], 2'b00};
  assign unused_alt_lsb = ^bus.Alt_PC_IN[1:0];

  assign do_pop   = !redirect && !freeze && (count_q != 3'd0);
  assign do_push  = (state_q == StReq) && ack && !redirect;
  assign tail     = count_q - {2'b00, do_pop};
  // Occupancy after this edge's pop/push; the completing request no longer holds a credit.
  assign space_ok = count_d < Depth;

  always_comb begin
    q_d = q_q;
    if (do_pop) begin
      for (int i = 0; i < int'(QUEUE_DEPTH) - 1; i++) q_d[i] = q_q[i+1];
    end
    if (do_push) begin
      for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
        if (i == int'(tail)) q_d[i] = {bus.IMem_Data_IN, addr_q};
      end
    end
    count_d = redirect ? 3'd0 : tail + {2'b00, do_push};
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= StReq;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
    end else begin
      unique case (state_q)
        StReq: begin
          if (redirect) begin
            pc_q <= alt_pc;
            if (ack) begin
              addr_q  <= alt_pc;
              state_q <= StReq;
            end else begin
              state_q <= StSquash;
            end
          end else if (ack) begin
            pc_q    <= pc_q + 32'd4;
            addr_q  <= pc_q + 32'd4;
            state_q <= space_ok ? StReq : StIdle;
          end
        end
        StSquash: begin
          if (redirect) pc_q <= alt_pc;
          if (ack) begin
            addr_q  <= redirect ? alt_pc : pc_q;
            state_q <= StReq;
          end
        end
        StIdle: begin
          if (redirect) begin
            pc_q    <= alt_pc;
            addr_q  <= alt_pc;
            state_q <= StReq;
          end else if (space_ok) begin
            addr_q  <= pc_q;
            state_q <= StReq;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < int'(QUEUE_DEPTH); i++) q_q[i] <= '0;
      count_q <= 3'd0;
      instr_q <= NOP_INSTR;
      ipc_q   <= 32'd0;
      ipc4_q  <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      q_q     <= q_d;
      count_q <= count_d;
      if (do_pop) begin
        instr_q <= q_q[0].instr;
        ipc_q   <= q_q[0].pc;
        ipc4_q  <= q_q[0].pc + 32'd4;
        valid_q <= 1'b1;
      end else if (!freeze) begin
        // Covers an empty queue and a redirect that kills the wrong-path slot.
        instr_q <= NOP_INSTR;
        ipc_q   <= 32'd0;
        ipc4_q  <= 32'd0;
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.IMem_Req_OUT       = ((state_q == StReq) || (state_q == StSquash)) && RESET;
  assign bus.IMem_Addr_OUT      = addr_q;
  assign bus.Instr1_OUT         = instr_q;
  assign bus.Instr_PC_OUT       = ipc_q;
  assign bus.Instr_PC_Plus4_OUT = ipc4_q;
  assign bus.Instr_Valid_OUT    = valid_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit against a queue-based reference model of the fetch
// stage, with a wait-state memory model and decode-side redirect/freeze stimulus.
module tb_instr_fetch_unit;

  localparam logic [31:0] ResetPc = 32'h0040_0000;
  localparam logic [31:0] Nop     = 32'h0000_0000;
  localparam int          Depth   = 2;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  logic CLK;
  logic RESET;
  instr_fetch_unit_if bus ();

  instr_fetch_unit #(
    .RESET_PC    (ResetPc),
    .NOP_INSTR   (Nop),
    .QUEUE_DEPTH (Depth)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  ent_t        mq [$];
  logic [31:0] m_pc, m_addr, m_instr, m_opc, m_p4;
  logic        m_out, m_sq, m_valid;
  int          mem_wait;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc     = ResetPc;
    m_addr   = ResetPc;
    m_out    = 1'b1;
    m_sq     = 1'b0;
    m_instr  = Nop;
    m_opc    = '0;
    m_p4     = '0;
    m_valid  = 1'b0;
    mem_wait = 0;
  endtask

  task automatic bubble();
    m_instr = Nop;
    m_opc   = '0;
    m_p4    = '0;
    m_valid = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_req",   {31'b0, bus.IMem_Req_OUT},    32'd0);
    check_eq("rst_addr",  bus.IMem_Addr_OUT,            ResetPc);
    check_eq("rst_instr", bus.Instr1_OUT,               Nop);
    check_eq("rst_pc",    bus.Instr_PC_OUT,             32'd0);
    check_eq("rst_pc4",   bus.Instr_PC_Plus4_OUT,       32'd0);
    check_eq("rst_valid", {31'b0, bus.Instr_Valid_OUT}, 32'd0);
  endtask

  // Called at a negedge: compare, drive the next edge's inputs, advance the model.
  task automatic cycle(input int wmin, input int wmax, input int rpct, input int fpct,
                       input logic [31:0] alt_fix);
    logic        redir, frz, ack, done;
    logic [31:0] alt, data;
    ent_t        e;

    check_eq("valid", {31'b0, bus.Instr_Valid_OUT}, {31'b0, m_valid});
    check_eq("instr", bus.Instr1_OUT, m_instr);
    check_eq("ipc",   bus.Instr_PC_OUT, m_opc);
    check_eq("ipc4",  bus.Instr_PC_Plus4_OUT, m_p4);
    check_eq("req",   {31'b0, bus.IMem_Req_OUT}, {31'b0, m_out});
    if (m_out) check_eq("addr", bus.IMem_Addr_OUT, m_addr);

    redir = int'($urandom_range(99)) < rpct;
    frz   = int'($urandom_range(99)) < fpct;
    if (alt_fix != 32'd0)              alt = alt_fix;
    else if ($urandom_range(7) == 0)   alt = 32'hFFFF_FFF0 | 32'($urandom_range(15));
    else                               alt = $urandom;
    ack = 1'b0;
    if (m_out) begin
      if (mem_wait == 0) begin
        ack      = 1'b1;
        mem_wait = int'($urandom_range(wmax, wmin));
      end else begin
        mem_wait--;
      end
    end
    data = ack ? (m_addr ^ 32'h0000_FFFF) : $urandom;

    bus.Request_Alt_PC_IN = redir;
    bus.Alt_PC_IN         = alt;
    bus.WANT_FREEZE_IN    = frz;
    bus.IMem_Ack_IN       = ack;
    bus.IMem_Data_IN      = data;

    // Decode side
    if (redir) begin
      mq.delete();
      if (!frz) bubble();
    end else if (!frz) begin
      if (mq.size() > 0) begin
        e       = mq.pop_front();
        m_instr = e.instr;
        m_opc   = e.pc;
        m_p4    = e.pc + 32'd4;
        m_valid = 1'b1;
      end else begin
        bubble();
      end
    end

    // Fetch side
    done = m_out && ack;
    if (done && !m_sq && !redir) begin
      mq.push_back({data, m_addr});
      m_pc = m_addr + 32'd4;
    end
    if (redir) m_pc = {alt[31:2], 2'b00};
    if (m_out && !done) begin
      if (redir) m_sq = 1'b1;
    end else begin
      m_sq = 1'b0;
      if (mq.size() < Depth) begin
        m_out  = 1'b1;
        m_addr = m_pc;
      end else begin
        m_out = 1'b0;
      end
    end

    @(negedge CLK);
  endtask

  task automatic run_phase(input int cycles, input int wmin, input int wmax, input int rpct,
                           input int fpct, input logic [31:0] alt_fix);
    for (int i = 0; i < cycles; i++) cycle(wmin, wmax, rpct, fpct, alt_fix);
  endtask

  task automatic drive_idle();
    bus.Request_Alt_PC_IN = 1'b0;
    bus.Alt_PC_IN         = '0;
    bus.WANT_FREEZE_IN    = 1'b0;
    bus.IMem_Ack_IN       = 1'b0;
    bus.IMem_Data_IN      = '0;
  endtask

  initial begin
    RESET = 1'b0;
    drive_idle();
    repeat (2) @(negedge CLK);
    check_reset_outputs();
    model_reset();
    RESET = 1'b1;
    #1;

    run_phase(12, 0, 0, 0, 0, 32'd0);              // zero-wait streaming
    run_phase(16, 3, 3, 0, 0, 32'd0);              // three wait states
    run_phase(4, 0, 0, 0, 0, 32'd0);
    run_phase(5, 0, 0, 0, 100, 32'd0);             // freeze fills the queue
    run_phase(6, 0, 0, 0, 0, 32'd0);
    run_phase(2, 2, 2, 0, 0, 32'd0);
    run_phase(1, 2, 2, 100, 0, 32'h0040_0102);     // redirect while outstanding
    run_phase(8, 2, 2, 0, 0, 32'd0);
    run_phase(1, 0, 0, 100, 100, 32'h0040_0208);   // redirect with freeze
    run_phase(6, 0, 0, 0, 0, 32'd0);
    run_phase(1500, 0, 3, 8, 20, 32'd0);

    // Asynchronous reset mid-stream
    run_phase(4, 0, 0, 0, 100, 32'd0);
    #2;
    RESET = 1'b0;
    drive_idle();
    #1;
    check_reset_outputs();
    model_reset();
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    #1;

    run_phase(20, 0, 0, 0, 0, 32'd0);
    run_phase(500, 0, 2, 10, 25, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage feeding the decode stage. Generates PCs and issues word requests to instruction memory over a req/ack handshake.
- Buffers returned words in a 2-entry queue and delivers one instruction per cycle to decode.
- Honours decode's redirect (Alt_PC / Request_Alt_PC) and freeze (WANT_FREEZE) signals; inserts NOP bubbles when nothing valid is available.

Parameters:
- RESET_PC, 32'h00400000, first fetch address after reset.
- NOP_INSTR, 32'h00000000, word emitted to decode as a bubble.
- QUEUE_DEPTH, 2, fetch-queue entries; legal values 1..4.

Ports:
- CLK  in  1  clock.
- RESET  in  1  asynchronous, active-low reset.
- Alt_PC_IN  in  32  redirect target from decode.
- Request_Alt_PC_IN  in  1  redirect strobe from decode, sampled each posedge.
- WANT_FREEZE_IN  in  1  decode requests that its input be held.
- IMem_Req_OUT  out  1  instruction-memory request.
- IMem_Addr_OUT  out  32  request address, word aligned.
- IMem_Ack_IN  in  1  memory completes the request this cycle.
- IMem_Data_IN  in  32  instruction word; valid only when IMem_Ack_IN=1.
- Instr1_OUT  out  32  instruction to decode.
- Instr_PC_OUT  out  32  PC of Instr1_OUT.
- Instr_PC_Plus4_OUT  out  32  Instr_PC_OUT+4.
- Instr_Valid_OUT  out  1  1 = real instruction, 0 = bubble.

Behaviour:
- Reset, asynchronous, while RESET=0:
  - Instr1_OUT=NOP_INSTR; Instr_PC_OUT=0; Instr_PC_Plus4_OUT=0; Instr_Valid_OUT=0.
  - IMem_Req_OUT=0; IMem_Addr_OUT=RESET_PC.
  - Queue empty; PC=RESET_PC; state=REQ.
  - Reset mid-request abandons the request; memory must tolerate the dropped Req.
- Request rules:
  - IMem_Req_OUT = (state==REQ || state==SQUASH) && RESET. Combinational from the state register.
  - IMem_Addr_OUT is registered and held stable from Req rise until the ack edge.
  - At most one request is outstanding.
- Credit accounting:
  - space = QUEUE_DEPTH - occupancy - (outstanding ? 1 : 0), with pop/push effects of the same edge applied.
  - A new request issues only if space > 0.
- State machine (IDLE/REQ/SQUASH); priority is redirect, then ack, then space:
  - REQ, ack, no redirect: push {data, addr} to the tail; PC <= PC+4; IMem_Addr_OUT <= PC+4. Next state REQ if space>0 after the push, else IDLE.
  - REQ, redirect, ack same edge: discard data; PC and IMem_Addr_OUT <= {Alt_PC_IN[31:2], 2'b00}; next state REQ.
  - REQ, redirect, no ack: PC <= aligned Alt_PC_IN; IMem_Addr_OUT held; next state SQUASH.
  - SQUASH, ack: discard data; IMem_Addr_OUT <= PC; next state REQ. A redirect on the same edge updates PC first and uses that PC as the address.
  - SQUASH, redirect, no ack: PC <= aligned Alt_PC_IN; stay in SQUASH.
  - IDLE, redirect: PC and IMem_Addr_OUT <= aligned Alt_PC_IN; next state REQ.
  - IDLE, space>0: IMem_Addr_OUT <= PC; next state REQ.
- Queue and decode interface, per posedge:
  - Redirect: flush the queue. If WANT_FREEZE_IN=0, output NOP_INSTR with Valid=0 and PCs=0 (kills the wrong-path instruction after the delay slot). If frozen, outputs hold.
  - Else frozen: outputs hold; no pop; pushes still allowed up to capacity.
  - Else queue non-empty: pop the head to the outputs with Valid=1.
  - Else: NOP_INSTR with Valid=0 and PCs=0.
  - No bypass: an acked word reaches Instr1_OUT no earlier than the edge after its ack edge.
  - Push and pop on the same edge are legal at any occupancy.
- Arithmetic:
  - PC+4 wraps modulo 2^32.
  - Alt_PC_IN[1:0] are ignored.
  - Instr_PC_Plus4_OUT = Instr_PC_OUT+4 for valid entries, 0 for bubbles.
- Throughput:
  - Zero-wait memory (ack in the Req cycle) sustains 1 instruction/cycle.
  - With N wait states: 1 instruction per N+1 cycles.

Test Plan:
- Reset release, ack every Req cycle, data=addr^32'hFFFF: IMem_Addr_OUT 0x00400000, 0x00400004, 0x00400008…; Instr1_OUT=0x0040FFFF valid at edge 2 after reset, then one valid instruction per cycle, Plus4 correct.
- Memory with 3 wait states: IMem_Addr_OUT stable for 4 cycles per word; decode sees valid words every 4th cycle with NOP/Valid=0 in between.
- WANT_FREEZE high for 5 cycles with zero-wait memory: outputs hold the same word; queue fills to 2; Req drops. On release, the queued words 0x…0C and 0x…10 are delivered on consecutive edges with no gap and no duplication.
- Request_Alt_PC with Alt_PC=0x00400102 while a request is outstanding (ack 2 cycles later): SQUASH entered; stale data discarded; next edge outputs NOP/Valid=0; next request address 0x00400100, and its word is the next valid output.
- Redirect coincident with ack and with WANT_FREEZE=1: acked word discarded; outputs hold; queue empty; next Req address is the aligned Alt_PC.
- RESET asserted while Req=1 and the queue holds 2 entries: Req drops immediately; all outputs at reset values; after release, fetch restarts at 0x00400000.
